// File: rtl/cl_sde_img_gen.sv
// Host-side image-stream transmitter and result collector.
// Emits NUM_IMG images of IMG_BEATS 512-bit beats, counts returned results,
// times the run and exposes everything on a small 12-bit register bus.
module cl_sde_img_gen #(
    parameter int          IMG_BEATS = 98,
    parameter logic [31:0] LFSR_INIT = 32'hACE1_0001
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [11:0]  cfg_addr,
    input  logic         cfg_wr,
    input  logic         cfg_rd,
    input  logic [31:0]  cfg_wdata,
    output logic         cfg_ack,
    output logic [31:0]  cfg_rdata,
    output logic         ots_valid,
    output logic [511:0] ots_data,
    output logic [63:0]  ots_keep,
    output logic [63:0]  ots_user,
    output logic         ots_last,
    input  logic         ots_ready,
    input  logic         ins_valid,
    input  logic [511:0] ins_data,
    input  logic [63:0]  ins_keep,
    input  logic [63:0]  ins_user,
    input  logic         ins_last,
    output logic         ins_ready
);
    localparam logic [15:0] LAST_BEAT = 16'(IMG_BEATS - 1);
    // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic [1:0]  rst_ff;
    logic        rst_i;
    logic        pat, res_bp, run_pat, stop_pend;
    logic        done, aborted, res_ovf;
    logic [31:0] num_img, seed, img_sent, res_rcvd, res_nx, last_res, lfsr, lfsr_nx, rd_val;
    logic [15:0] beat_cnt;
    logic [63:0] timer;
    logic        wr_ctrl, go, stop, xfer, res_hs, busy, res_bp_nx;
    logic        set_done, set_abort;
    logic [7:0][63:0] pat_lane;
    logic        unused;

    assign unused = ^{ins_keep, ins_user, ins_last, ins_data[511:32]};

    // Reset asserts immediately, releases two clocks after rst_n rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_ff <= 2'b00;
        else        rst_ff <= {rst_ff[0], 1'b1};
    end
    assign rst_i = rst_ff[1];

    assign busy      = (state == SEND) || (state == DRAIN);
    assign wr_ctrl   = cfg_wr && (cfg_addr == 12'h000);
    assign go        = wr_ctrl && cfg_wdata[0] && !busy;
    assign stop      = wr_ctrl && cfg_wdata[1];
    assign xfer      = ots_valid && ots_ready;
    assign res_hs    = ins_valid && ins_ready;
    assign res_nx    = (res_hs && res_rcvd != 32'hFFFF_FFFF) ? res_rcvd + 32'd1 : res_rcvd;
    assign lfsr_nx   = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    assign res_bp_nx = wr_ctrl ? cfg_wdata[3] : res_bp;

    // Beat pattern: 8 lanes of 64 bits, either counter-tagged or LFSR-derived
    for (genvar k = 0; k < 8; k++) begin : g_lane
        assign pat_lane[k] = run_pat ? {lfsr, lfsr ^ {29'b0, 3'(k)}}
                                     : {img_sent, beat_cnt, 13'b0, 3'(k)};
    end

    assign ots_valid = (state == SEND);
    assign ots_last  = ots_valid && (beat_cnt == LAST_BEAT);
    assign ots_data  = ots_valid ? pat_lane : '0;
    assign ots_keep  = '1;
    assign ots_user  = '0;

    // State register
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state plus done/aborted set conditions
    always_comb begin
        state_nx  = state;
        set_done  = 1'b0;
        set_abort = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (go) begin
                    if (num_img == 32'd0) begin
                        state_nx = DONE;
                        set_done = 1'b1;
                    end else begin
                        state_nx = SEND;
                    end
                end
            end
            SEND: begin
                // A presented beat always completes before a stop takes effect
                if (xfer && (stop || stop_pend)) begin
                    state_nx  = DONE;
                    set_done  = 1'b1;
                    set_abort = 1'b1;
                end else if (ots_last && xfer && (img_sent + 32'd1 == num_img)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (stop) begin
                    state_nx  = DONE;
                    set_done  = 1'b1;
                    set_abort = 1'b1;
                end else if (res_nx >= num_img) begin
                    state_nx = DONE;
                    set_done = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Run datapath: counters, LFSR, timer, status bits, result capture
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            pat <= 1'b0;  res_bp <= 1'b0;  run_pat <= 1'b0;  stop_pend <= 1'b0;
            done <= 1'b0; aborted <= 1'b0; res_ovf <= 1'b0;
            num_img <= '0; seed <= '0; img_sent <= '0; res_rcvd <= '0; last_res <= '0;
            beat_cnt <= '0; timer <= '0; lfsr <= LFSR_INIT; ins_ready <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                pat    <= cfg_wdata[2];
                res_bp <= cfg_wdata[3];
            end
            if (cfg_wr && cfg_addr == 12'h004) num_img <= cfg_wdata;
            if (cfg_wr && cfg_addr == 12'h01C) seed    <= cfg_wdata;
            if (go) begin
                img_sent <= '0; res_rcvd <= '0; timer <= '0; beat_cnt <= '0;
                stop_pend <= 1'b0; done <= 1'b0; aborted <= 1'b0; res_ovf <= 1'b0;
                lfsr    <= (seed == 32'd0) ? LFSR_INIT : seed;
                run_pat <= cfg_wdata[2];
            end else begin
                if (xfer) begin
                    lfsr <= lfsr_nx;
                    if (ots_last) begin
                        beat_cnt <= '0;
                        img_sent <= img_sent + 32'd1;
                    end else begin
                        beat_cnt <= beat_cnt + 16'd1;
                    end
                end
                if (stop && state == SEND) stop_pend <= 1'b1;
                if (res_hs) begin
                    res_rcvd <= res_nx;
                    last_res <= ins_data[31:0];
                    if (res_rcvd >= num_img || !busy) res_ovf <= 1'b1;
                end
                if (busy) timer <= timer + 64'd1;
            end
            if (set_done)  done    <= 1'b1;
            if (set_abort) aborted <= 1'b1;
            // Backpressure mode alternates ready, restarting high on GO
            ins_ready <= res_bp_nx ? (go ? 1'b1 : ~ins_ready) : 1'b1;
        end
    end

    // Register read decode
    always_comb begin
        rd_val = 32'hDEAD_BEEF;
        case (cfg_addr)
            12'h000: rd_val = {28'b0, res_bp, pat, 2'b00};
            12'h004: rd_val = num_img;
            12'h008: rd_val = {28'b0, res_ovf, aborted, done, busy};
            12'h00C: rd_val = img_sent;
            12'h010: rd_val = res_rcvd;
            12'h014: rd_val = timer[31:0];
            12'h018: rd_val = timer[63:32];
            12'h01C: rd_val = seed;
            12'h020: rd_val = last_res;
            default: rd_val = 32'hDEAD_BEEF;
        endcase
    end

    // One-cycle acknowledge; read data only valid alongside it
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            cfg_ack   <= 1'b0;
            cfg_rdata <= '0;
        end else begin
            cfg_ack   <= cfg_wr || cfg_rd;
            cfg_rdata <= cfg_rd ? rd_val : 32'd0;
        end
    end
endmodule

// File: tb/tb_cl_sde_img_gen.sv
// Bench for cl_sde_img_gen: directed runs checked against a beat-level model.
module tb_cl_sde_img_gen;
    localparam int          NB   = 4;
    localparam logic [31:0] INIT = 32'hACE1_0001;

    logic clk = 1'b0, rst_n = 1'b1;
    logic [11:0] cfg_addr = '0;
    logic cfg_wr = 1'b0, cfg_rd = 1'b0, cfg_ack;
    logic [31:0] cfg_wdata = '0, cfg_rdata;
    logic ots_valid, ots_last, ots_ready = 1'b0;
    logic [511:0] ots_data, ins_data;
    logic [63:0] ots_keep, ots_user;
    logic [63:0] ins_keep = '0, ins_user = '0;
    logic ins_valid, ins_last = 1'b0, ins_ready;
    logic resp_valid = 1'b0, man_valid = 1'b0, resp_en = 1'b0;
    logic [31:0] resp_data = '0, man_data = '0;

    assign ins_valid = resp_valid | man_valid;
    assign ins_data  = {480'b0, resp_valid ? resp_data : man_data};

    cl_sde_img_gen #(.IMG_BEATS(NB), .LFSR_INIT(INIT)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_addr(cfg_addr), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
        .cfg_wdata(cfg_wdata), .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata),
        .ots_valid(ots_valid), .ots_data(ots_data), .ots_keep(ots_keep), .ots_user(ots_user),
        .ots_last(ots_last), .ots_ready(ots_ready), .ins_valid(ins_valid), .ins_data(ins_data),
        .ins_keep(ins_keep), .ins_user(ins_user), .ins_last(ins_last), .ins_ready(ins_ready)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, nres = 0;
    int q[$];

    // model state
    bit m_run = 0, m_pat = 0, m_held = 0;
    int m_img, m_beat, m_xfers, m_total, lasts, vld_cycles = 0;
    logic [31:0] m_lfsr;
    logic [511:0] m_held_data;
    logic [63:0] first_lane0, b5l2;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Galois LFSR step built from the polynomial exponents
    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        int taps[4] = '{32, 22, 2, 1};
        logic [31:0] mask;
        mask = '0;
        foreach (taps[i]) mask[taps[i]-1] = 1'b1;
        return x[0] ? ((x >> 1) ^ mask) : (x >> 1);
    endfunction

    function automatic logic [511:0] exp_beat(input bit p, input int img, input int beat, input logic [31:0] lf);
        logic [511:0] d;
        for (int k = 0; k < 8; k++)
            d[64*k +: 64] = p ? {lf, lf ^ 32'(k)} : {32'(img), 16'(beat), 16'(k)};
        return d;
    endfunction

    task automatic model_start(input bit p, input logic [31:0] sd, input int total);
        m_pat = p; m_lfsr = (sd == 0) ? INIT : sd;
        m_img = 0; m_beat = 0; m_xfers = 0; m_total = total; lasts = 0; m_held = 0;
        first_lane0 = 'x; b5l2 = 'x; m_run = 1;
    endtask

    always @(posedge clk) cyc++;

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ots_keep", ots_keep, {64{1'b1}});
            chk("ots_user", ots_user, 64'd0);
        end
        if (!m_run) chk("valid_no_run", ots_valid, 1'b0);
        if (ots_valid) begin
            vld_cycles++;
            if (m_run) begin
                chk("beat_in_run", m_xfers < m_total, 1'b1);
                chk("ots_data", ots_data, exp_beat(m_pat, m_img, m_beat, m_lfsr));
                chk("ots_last", ots_last, m_beat == NB - 1);
                if (m_held) chk("held_data", ots_data, m_held_data);
                if (m_xfers == 0) first_lane0 = ots_data[63:0];
                if (m_xfers == 5) b5l2 = ots_data[191:128];
                if (ots_ready) begin
                    m_xfers++;
                    if (ots_last) begin
                        lasts++;
                        if (resp_en) q.push_back(cyc + 10);
                    end
                    m_lfsr = lfsr_step(m_lfsr);
                    if (m_beat == NB - 1) begin m_beat = 0; m_img++; end
                    else m_beat++;
                    m_held = 0;
                end else begin
                    m_held = 1; m_held_data = ots_data;
                end
            end
        end else if (rst_n) begin
            chk("last_idle", ots_last, 1'b0);
        end
    end

    // Result responder: one result beat 10 cycles after each image's last beat
    initial forever begin
        @(posedge clk); #1;
        resp_valid = 1'b0;
        if (!rst_n) q.delete();
        else if (q.size() > 0 && q[0] <= cyc) begin
            void'(q.pop_front());
            resp_valid = 1'b1;
            resp_data  = 32'hA000_0000 + 32'(nres);
            nres++;
        end
    end

    task automatic cfg_write(input logic [11:0] a, input logic [31:0] d);
        cfg_addr = a; cfg_wdata = d; cfg_wr = 1'b1;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
    endtask

    task automatic cfg_read(input logic [11:0] a, output logic [31:0] d);
        cfg_addr = a; cfg_rd = 1'b1;
        @(posedge clk); #1;
        cfg_rd = 1'b0;
        chk("cfg_ack", cfg_ack, 1'b1);
        d = cfg_rdata;
    endtask

    task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] e);
        logic [31:0] v;
        cfg_read(a, v);
        chk(nm, v, e);
    endtask

    task automatic wait_done(input int budget);
        logic [31:0] s;
        int n = 0;
        do begin cfg_read(12'h008, s); n++; end while (!s[1] && n < budget);
        chk("wait_done", s[1], 1'b1);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] regs[9] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010,
                                 12'h014, 12'h018, 12'h01C, 12'h020};
        int v0;
        #1 rst_n = 1'b0;
        tick(3);
        chk("rst_ots_valid", ots_valid, 1'b0);
        chk("rst_ots_data", ots_data, 512'd0);
        chk("rst_ots_keep", ots_keep, {64{1'b1}});
        chk("rst_cfg_ack", cfg_ack, 1'b0);
        chk("rst_ins_ready", ins_ready, 1'b0);
        rst_n = 1'b1;
        tick(4);
        chk("model_lfsr_step", lfsr_step(32'h1), 32'h8020_0003);
        rd_chk("unmapped", 12'h024, 32'hDEAD_BEEF);

        // counter pattern, 2 images, always ready
        resp_en = 1; ots_ready = 1;
        cfg_write(12'h004, 32'd2);
        cfg_write(12'h000, 32'h1);
        model_start(0, 0, 2 * NB);
        wait_done(100);
        chk("s1_beats", m_xfers, 8);
        chk("s1_lasts", lasts, 2);
        chk("s1_b5_lane2", b5l2, 64'h00000001_0001_0002);
        rd_chk("s1_status", 12'h008, 32'h2);
        rd_chk("s1_res_rcvd", 12'h010, 32'd2);
        rd_chk("s1_img_sent", 12'h00C, 32'd2);
        rd_chk("s1_last_res", 12'h020, 32'hA000_0001);
        rd_chk("s1_timer_lo", 12'h014, 32'd18);
        rd_chk("s1_timer_hi", 12'h018, 32'd0);

        // LFSR pattern with random ready
        cfg_write(12'h01C, 32'd1);
        cfg_write(12'h000, 32'h5);
        model_start(1, 1, 2 * NB);
        for (int i = 0; i < 400 && m_xfers < 8; i++) begin
            ots_ready = 1'($urandom_range(0, 1));
            tick(1);
        end
        ots_ready = 1;
        chk("s2_beats", m_xfers, 8);
        chk("s2_beat0_lane0", first_lane0, {32'h1, 32'h1});
        wait_done(100);
        rd_chk("s2_res_rcvd", 12'h010, 32'd2);
        rd_chk("s2_seed", 12'h01C, 32'd1);

        // zero images
        v0 = vld_cycles;
        cfg_write(12'h004, 32'd0);
        cfg_write(12'h000, 32'h1);
        model_start(0, 0, 0);
        rd_chk("s3_status", 12'h008, 32'h2);
        tick(3);
        chk("s3_no_valid", vld_cycles, v0);

        // STOP mid-image while the beat is held
        resp_en = 0; ots_ready = 1;
        cfg_write(12'h004, 32'd3);
        cfg_write(12'h000, 32'h1);
        model_start(0, 0, 3 * NB);
        for (int i = 0; i < 50 && m_xfers < 2; i++) tick(1);
        ots_ready = 0;
        cfg_write(12'h000, 32'h2);
        tick(4);
        chk("s4_held_valid", ots_valid, 1'b1);
        ots_ready = 1;
        tick(3);
        chk("s4_beats", m_xfers, 3);
        chk("s4_valid_off", ots_valid, 1'b0);
        rd_chk("s4_status", 12'h008, 32'h6);
        rd_chk("s4_img_sent", 12'h00C, 32'd0);

        // asynchronous reset in the middle of a run
        cfg_write(12'h004, 32'd2);
        cfg_write(12'h000, 32'h1);
        model_start(0, 0, 2 * NB);
        for (int i = 0; i < 50 && m_xfers < 3; i++) tick(1);
        #2;
        m_run = 0; rst_n = 1'b0;
        #1;
        chk("s6_valid_async", ots_valid, 1'b0);
        chk("s6_data_async", ots_data, 512'd0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        foreach (regs[i]) rd_chk($sformatf("s6_reg_%0h", regs[i]), 12'(regs[i]), 32'd0);

        // result while idle
        man_data = 32'h1234_5678; man_valid = 1;
        tick(1);
        man_valid = 0;
        rd_chk("s5_res_rcvd", 12'h010, 32'd1);
        rd_chk("s5_last_res", 12'h020, 32'h1234_5678);
        rd_chk("s5_status", 12'h008, 32'h8);

        // normal run after reset
        resp_en = 1;
        cfg_write(12'h004, 32'd1);
        cfg_write(12'h000, 32'h1);
        model_start(0, 0, NB);
        wait_done(100);
        chk("s7_beats", m_xfers, NB);
        rd_chk("s7_res_rcvd", 12'h010, 32'd1);
        rd_chk("s7_status", 12'h008, 32'h2);
        rd_chk("s7_img_sent", 12'h00C, 32'd1);

        // result backpressure toggling from GO
        cfg_write(12'h004, 32'd0);
        cfg_write(12'h000, 32'h9);
        model_start(0, 0, 0);
        chk("bp_ready0", ins_ready, 1'b1);
        tick(1);
        chk("bp_ready1", ins_ready, 1'b0);
        tick(1);
        chk("bp_ready2", ins_ready, 1'b1);
        cfg_write(12'h000, 32'h0);
        tick(2);
        chk("bp_off", ins_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cl_sde_img_gen.md
Name: cl_sde_img_gen

Overview:
- Register-programmable image-stream transmitter and result collector: the host-side counterpart of the SDE stream-processing block.
- Generates NUM_IMG images of IMG_BEATS 512-bit AXI-stream beats on ots_*, with ots_last on the final beat of each image.
- Accepts the 160-bit classification results returned on ins_*, counts them, and times the whole run.
- Status and counters are read over the 12-bit cfg register bus.

Parameters:
- IMG_BEATS, 98, beats per image (1..65535).
- LFSR_INIT, 32'hACE1_0001, power-on LFSR seed, used when SEED is written as 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_addr  in  12  register byte address
- cfg_wr  in  1  write strobe, one cycle
- cfg_rd  in  1  read strobe, one cycle
- cfg_wdata  in  32  write data
- cfg_ack  out  1  access acknowledge
- cfg_rdata  out  32  read data, valid with cfg_ack
- ots_valid  out  1  image beat valid
- ots_data  out  512  image beat data
- ots_keep  out  64  byte enables, always all-ones
- ots_user  out  64  always 0
- ots_last  out  1  last beat of image
- ots_ready  in  1  downstream ready
- ins_valid  in  1  result beat valid
- ins_data  in  512  result, bits [159:0] meaningful
- ins_keep  in  64  ignored
- ins_user  in  64  ignored
- ins_last  in  1  ignored, every beat is one result
- ins_ready  out  1  result ready

Behaviour:
- Reset values: all outputs 0 except ots_keep = all-ones; registers 0; FSM in IDLE; LFSR = LFSR_INIT.
- Reset is asynchronous assert, synchronous deassert. Reset mid-run abandons the run immediately, with no completion of an in-flight beat.
- cfg bus: cfg_ack pulses 1 cycle after cfg_wr or cfg_rd. For reads, cfg_rdata is valid only in that cycle; 32'hDEAD_BEEF for unmapped addresses.
- Register map:
  - 0x00 CTRL: b0 GO (write-1 pulse, reads 0), b1 STOP (write-1 pulse), b2 PAT (0 = counter, 1 = LFSR), b3 RES_BP (result backpressure enable).
  - 0x04 NUM_IMG.
  - 0x08 STATUS (RO): b0 busy, b1 done, b2 aborted, b3 res_overflow.
  - 0x0C IMG_SENT (RO).
  - 0x10 RES_RCVD (RO).
  - 0x14 / 0x18 TIMER lo/hi (RO, 64-bit).
  - 0x1C SEED.
  - 0x20 LAST_RES[31:0] (RO).
- FSM: IDLE -> SEND -> DRAIN -> DONE.
  - IDLE/DONE + GO: clear IMG_SENT, RES_RCVD, TIMER and the status bits; load LFSR from SEED (or LFSR_INIT if SEED = 0); beat_cnt = 0; go to SEND. If NUM_IMG = 0, go directly to DONE with done = 1, emitting no beats.
  - GO while busy: ignored.
  - SEND: ots_valid = 1. A beat transfers on ots_valid & ots_ready. Once asserted, ots_valid and ots_data/last stay stable until the transfer.
  - ots_last = (beat_cnt == IMG_BEATS-1). On a last transfer: IMG_SENT++, beat_cnt = 0. When IMG_SENT reaches NUM_IMG, go to DRAIN with ots_valid dropping the next cycle.
  - STOP in SEND: finish any presented beat (never deassert valid without handshake), then go to DONE with aborted = 1. STOP in DRAIN: DONE with aborted = 1.
  - DRAIN: wait until RES_RCVD == NUM_IMG, then DONE with done = 1. busy = 1 in SEND and DRAIN.
- Data pattern:
  - Counter: lane k (k = 0..7, bits 64k+63:64k) = {IMG_SENT[31:0], beat_cnt[15:0], 13'b0, k[2:0]}.
  - LFSR: lane k = {lfsr, lfsr ^ {29'b0, k}}. LFSR is 32-bit Galois, taps x^32+x^22+x^2+x+1, advanced once per transferred beat only.
- Results:
  - ins_ready = 1 in all states when RES_BP = 0. When RES_BP = 1, ins_ready toggles every cycle (starts 1 after GO).
  - Each ins handshake: RES_RCVD++ (saturating at 2^32-1) and LAST_RES = ins_data[31:0].
  - A handshake when RES_RCVD ≥ NUM_IMG, or in IDLE/DONE, sets res_overflow but is still counted.
- TIMER increments every cycle while busy; freezes on DONE; wraps modulo 2^64.
- Simultaneous events: a result received in the same cycle as the final ots_last transfer is counted; the DRAIN exit check uses the updated count.

Test Plan:
- NUM_IMG=2, IMG_BEATS=4, PAT=0, ots_ready=1, results returned 10 cycles after each last -> 8 beats; last on beats 3 and 7; beat 5 lane 2 = 64'h00000001_0001_0002; done=1, RES_RCVD=2.
- Random ots_ready (50%) with PAT=1, SEED=1 -> data stable while valid&!ready; beat0 lane0 = {32'h1,32'h1}; LFSR advances only on transfers; matches reference model.
- NUM_IMG=0 + GO -> no ots_valid; STATUS=0x2 within 2 cycles of ack.
- STOP written mid-image with ots_ready=0 for 5 cycles after -> held beat transfers once ready=1; then DONE; STATUS=0x6; IMG_SENT unchanged.
- Result beat with ins_data[31:0]=32'h1234_5678 while IDLE -> RES_RCVD=1, LAST_RES=32'h12345678, res_overflow=1.
- rst_n asserted mid-SEND (asynchronously, between edges) -> ots_valid=0 immediately; all registers read 0; subsequent GO runs normally.
